// File: rtl/mc_pipe_dff_pkg.sv
// Shared helpers for the mc_* pipeline register family.
package mc_pipe_dff_pkg;

  // Elaboration-time ceil(log2(n)), used to size occupancy counters.
  function automatic int mc_clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mc_pipe_stage.sv
// One pipeline stage: a valid bit plus a data register that loads only valid words.
module mc_pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
  input  logic             CLK,
  input  logic             ARST_N,
  input  logic             flush,
  input  logic             adv,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid <= src_valid;
    end
  end

  // Data is left stale when the incoming slot is a bubble.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      data <= RST_VALUE;
    end else if (!flush && adv && src_valid) begin
      data <= src_data;
    end
  end

endmodule

// File: rtl/mc_pipe_dff.sv
// DEPTH-stage valid/ready register pipeline with bubble collapsing, flush and occupancy count.
module mc_pipe_dff
  import mc_pipe_dff_pkg::*;
#(
  parameter  int               WIDTH     = 8,
  parameter  int               DEPTH     = 4,
  parameter  logic [WIDTH-1:0] RST_VALUE = '0,
  localparam int               CNT_W     = mc_clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             ARST_N,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [CNT_W-1:0] COUNT
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d [DEPTH];
  logic             in_fire;
  logic             out_fire;
  logic [CNT_W-1:0] count_q;

  // A stage may advance when the output drains or any stage at or after it is empty;
  // written as a reduction rather than a ripple so no bit depends on a sibling bit.
  for (genvar i = 0; i < DEPTH; i++) begin : g_adv
    assign adv[i] = OUT_READY | ~(&v[DEPTH-1:i]);
  end

  assign IN_READY  = adv[0] & ~FLUSH & ARST_N;
  assign in_fire   = IN_VALID & IN_READY;
  assign OUT_VALID = v[DEPTH-1];
  assign OUT_DATA  = d[DEPTH-1];
  assign out_fire  = OUT_VALID & OUT_READY;
  assign COUNT     = count_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    if (i == 0) begin : g_head
      assign src_valid = in_fire;
      assign src_data  = IN_DATA;
    end else begin : g_body
      assign src_valid = v[i-1];
      assign src_data  = d[i-1];
    end
    mc_pipe_stage #(
      .WIDTH     (WIDTH),
      .RST_VALUE (RST_VALUE)
    ) u_stage (
      .CLK       (CLK),
      .ARST_N    (ARST_N),
      .flush     (FLUSH),
      .adv       (adv[i]),
      .src_valid (src_valid),
      .src_data  (src_data),
      .valid     (v[i]),
      .data      (d[i])
    );
  end

  // Occupancy tracks accepted minus delivered words; a flush empties every stage.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      count_q <= '0;
    end else if (FLUSH) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNT_W'(in_fire) - CNT_W'(out_fire);
    end
  end

endmodule

// File: tb/tb_mc_pipe_dff.sv
// Scoreboard bench for mc_pipe_dff: a DEPTH=4 and a DEPTH=1 instance share clock and reset.
module tb_mc_pipe_dff;

  logic        CLK = 1'b0;
  logic        ARST_N = 1'b0;
  logic        flush    [2];
  logic        inValid  [2];
  logic        outReady [2];
  logic [7:0]  inData   [2];
  logic        inReadyW  [2];
  logic        outValidW [2];
  logic [7:0]  outDataW  [2];
  logic [31:0] countW    [2];
  bit          latChk    [2];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rstVal(input int g);
    return (g == 0) ? 8'h00 : 8'hC3;
  endfunction

  function automatic int depthOf(input int g);
    return (g == 0) ? 4 : 1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gDut
    localparam int         D  = (g == 0) ? 4 : 1;
    localparam logic [7:0] RV = (g == 0) ? 8'h00 : 8'hC3;
    localparam int         CW = $clog2(D + 1);
    logic [CW-1:0] cnt;
    logic [7:0]    expQ[$];
    int            cycQ[$];
    int            occ = 0;
    logic          prevStall = 1'b0;
    logic [7:0]    prevData = '0;

    mc_pipe_dff #(.WIDTH(8), .DEPTH(D), .RST_VALUE(RV)) dut (
      .CLK       (CLK),
      .ARST_N    (ARST_N),
      .FLUSH     (flush[g]),
      .IN_VALID  (inValid[g]),
      .IN_READY  (inReadyW[g]),
      .IN_DATA   (inData[g]),
      .OUT_VALID (outValidW[g]),
      .OUT_READY (outReady[g]),
      .OUT_DATA  (outDataW[g]),
      .COUNT     (cnt)
    );
    assign countW[g] = 32'(cnt);

    // Reference: an ordered queue of accepted words with capacity D.
    always @(negedge CLK or negedge ARST_N) begin : mon
      logic inFire;
      logic outFire;
      int   fc;
      if (!ARST_N) begin
        expQ.delete();
        cycQ.delete();
        occ = 0;
        prevStall = 1'b0;
      end else begin
        inFire  = inValid[g] & inReadyW[g];
        outFire = outValidW[g] & outReady[g];
        checkOutput($sformatf("d%0d_in_ready", g), 32'(inReadyW[g]),
                    32'(((occ < D) || outReady[g]) && !flush[g]));
        checkOutput($sformatf("d%0d_count", g), countW[g], 32'(occ));
        if (prevStall) begin
          checkOutput($sformatf("d%0d_stall_valid", g), 32'(outValidW[g]), 32'd1);
          checkOutput($sformatf("d%0d_stall_data", g), 32'(outDataW[g]), 32'(prevData));
        end
        if (outFire) begin
          if (expQ.size() == 0) begin
            checkOutput($sformatf("d%0d_spurious_out", g), 32'(outValidW[g]), 32'd0);
          end else begin
            checkOutput($sformatf("d%0d_out_data", g), 32'(outDataW[g]), 32'(expQ.pop_front()));
            fc = cycQ.pop_front();
            if (latChk[g]) checkOutput($sformatf("d%0d_latency", g), 32'(cyc - fc), 32'(D));
          end
        end
        if (flush[g]) begin
          expQ.delete();
          cycQ.delete();
          occ = 0;
        end else begin
          if (inFire) begin
            expQ.push_back(inData[g]);
            cycQ.push_back(cyc);
          end
          occ = occ + int'(inFire) - int'(outFire);
        end
        prevStall = outValidW[g] & ~outReady[g] & ~flush[g];
        prevData  = outDataW[g];
      end
    end
  end

  task automatic applyStimulus(input int g, input logic v, input logic [7:0] d,
                               input logic ordy, input logic fl);
    inValid[g]  = v;
    inData[g]   = d;
    outReady[g] = ordy;
    flush[g]    = fl;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int g = 0; g < 2; g++) applyStimulus(g, 1'b1, 8'h77, 1'b0, 1'b0);

    // Reset held with IN_VALID high.
    @(negedge CLK);
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("d%0d_rst_in_ready", g), 32'(inReadyW[g]), 32'd0);
      checkOutput($sformatf("d%0d_rst_out_valid", g), 32'(outValidW[g]), 32'd0);
      checkOutput($sformatf("d%0d_rst_out_data", g), 32'(outDataW[g]), 32'(rstVal(g)));
      checkOutput($sformatf("d%0d_rst_count", g), countW[g], 32'd0);
    end
    @(posedge CLK);
    #2 ARST_N = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("d%0d_release_in_ready", g), 32'(inReadyW[g]), 32'd1);
      applyStimulus(g, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    step();

    // Streaming with latency measured on each word, for both depths.
    for (int g = 0; g < 2; g++) begin
      latChk[g] = 1'b1;
      for (int i = 1; i <= 16; i++) begin
        applyStimulus(g, 1'b1, 8'(i), 1'b1, 1'b0);
        step();
      end
      applyStimulus(g, 1'b0, 8'h00, 1'b1, 1'b0);
      repeat (depthOf(g) + 2) step();
      latChk[g] = 1'b0;
    end

    // Backpressure fill: only four of six offered words fit.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      step();
    end
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge CLK);
    checkOutput("fill_count", countW[0], 32'd4);
    checkOutput("fill_in_ready", 32'(inReadyW[0]), 32'd0);
    checkOutput("fill_out_data", 32'(outDataW[0]), 32'hA0);
    step();
    applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0);
    repeat (6) step();

    // Bubble collapse under a stalled output.
    applyStimulus(0, 1'b1, 8'h11, 1'b0, 1'b0);
    step();
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    applyStimulus(0, 1'b1, 8'h22, 1'b0, 1'b0);
    step();
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (4) step();
    @(negedge CLK);
    checkOutput("bubble_count", countW[0], 32'd2);
    checkOutput("bubble_in_ready", 32'(inReadyW[0]), 32'd1);
    checkOutput("bubble_out_valid", 32'(outValidW[0]), 32'd1);
    checkOutput("bubble_out_data", 32'(outDataW[0]), 32'h11);
    step();
    applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0);
    repeat (5) step();

    // Flush with three words held and the head delivered in the flush cycle.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1'b1, 8'h31 + 8'(i), 1'b0, 1'b0);
      step();
    end
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) step();
    applyStimulus(0, 1'b1, 8'h3F, 1'b1, 1'b1);
    @(negedge CLK);
    checkOutput("flush_in_ready", 32'(inReadyW[0]), 32'd0);
    checkOutput("flush_head_data", 32'(outDataW[0]), 32'h31);
    step();
    applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge CLK);
    checkOutput("flush_count", countW[0], 32'd0);
    checkOutput("flush_out_valid", 32'(outValidW[0]), 32'd0);
    repeat (5) step();

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1'b1, 8'h51 + 8'(i), 1'b0, 1'b0);
      step();
    end
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) step();
    @(negedge CLK);
    checkOutput("pre_reset_count", countW[0], 32'd3);
    @(posedge CLK);
    #2 ARST_N = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(outValidW[0]), 32'd0);
    checkOutput("midrst_count", countW[0], 32'd0);
    checkOutput("midrst_in_ready", 32'(inReadyW[0]), 32'd0);
    checkOutput("midrst_out_data", 32'(outDataW[0]), 32'(rstVal(0)));
    @(posedge CLK);
    #2 ARST_N = 1'b1;
    step();

    // Randomised traffic on both instances, including occasional flushes.
    for (int n = 0; n < 400; n++) begin
      for (int g = 0; g < 2; g++) begin
        applyStimulus(g, 1'($urandom_range(0, 1)), 8'($urandom),
                      1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0));
      end
      step();
    end
    for (int g = 0; g < 2; g++) applyStimulus(g, 1'b0, 8'h00, 1'b1, 1'b0);
    repeat (8) step();
    for (int g = 0; g < 2; g++)
      checkOutput($sformatf("d%0d_final_count", g), countW[g], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
